// File: rtl/dma64_pkg.sv
// Shared types and constants for the 64-bit DMA memory responder.
// Request classification lives here so every agent agrees on the error priority.
package dma64_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } dma_state_e;

    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_SIZE  = 2'b10;
    localparam logic [1:0] ERR_ZERO  = 2'b11;

    // Zero length dominates (nothing moves), then range, then size.
    function automatic logic [1:0] classify_req(input logic [31:0] idx,
                                                input logic [31:0] len,
                                                input logic [2:0]  size,
                                                input logic [32:0] depth);
        if (len == 32'd0)                              return ERR_ZERO;
        if (({1'b0, idx} + {1'b0, len}) > depth)       return ERR_RANGE;
        if (size != DMA_SIZE_64)                       return ERR_SIZE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dma64_beat_mem.sv
// Beat storage: one write port, two registered read ports (burst side and host side).
// Array contents are deliberately not reset; only the read registers are.
module dma64_beat_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [63:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [63:0]   rdata_b
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-backed DMA responder: serves one read or write burst at a time from a
// shared beat memory, with optional read-channel bubbles and error reporting.
module dma64_mem_responder
    import dma64_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int GAP_EVERY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_read_ctrl_valid,
    output logic        dma_read_ctrl_ready,
    input  logic [31:0] dma_read_ctrl_data_index,
    input  logic [31:0] dma_read_ctrl_data_length,
    input  logic [2:0]  dma_read_ctrl_data_size,
    input  logic [5:0]  dma_read_ctrl_data_user,
    output logic        dma_read_chnl_valid,
    input  logic        dma_read_chnl_ready,
    output logic [63:0] dma_read_chnl_data,
    input  logic        dma_write_ctrl_valid,
    output logic        dma_write_ctrl_ready,
    input  logic [31:0] dma_write_ctrl_data_index,
    input  logic [31:0] dma_write_ctrl_data_length,
    input  logic [2:0]  dma_write_ctrl_data_size,
    input  logic [5:0]  dma_write_ctrl_data_user,
    input  logic        dma_write_chnl_valid,
    output logic        dma_write_chnl_ready,
    input  logic [63:0] dma_write_chnl_data,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [63:0] host_wdata,
    output logic [63:0] host_rdata,
    output logic        busy,
    output logic        err_pulse,
    output logic [1:0]  err_code
);

    localparam int          AW       = $clog2(MEM_DEPTH);
    localparam bit          GAP_EN   = (GAP_EVERY > 0);
    localparam logic [31:0] GAP_LAST = GAP_EN ? 32'(GAP_EVERY - 1) : 32'd0;

    dma_state_e  state;
    logic        ctrl_rdy;
    logic [31:0] base_idx, xfer_len, issue_cnt, beat_cnt, gap_cnt;
    logic [2:0]  xfer_size;
    logic        s1_valid;
    logic [63:0] mem_rdata;

    // Request mux: read wins when both are offered in the same cycle.
    logic [31:0] req_idx, req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_err;
    logic        req_acc;
    assign req_idx  = dma_read_ctrl_valid ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign req_len  = dma_read_ctrl_valid ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign req_size = dma_read_ctrl_valid ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;
    assign req_err  = classify_req(req_idx, req_len, req_size, 33'(MEM_DEPTH));
    assign req_acc  = (state == IDLE) && ctrl_rdy && (dma_read_ctrl_valid || dma_write_ctrl_valid);

    // Read pipe: issue -> s1 (memory output) -> output register.
    logic rd_hs, last_rd, gap_hit, s1_take, can_issue, s1_hold;
    assign rd_hs     = dma_read_chnl_valid && dma_read_chnl_ready;
    assign last_rd   = rd_hs && (beat_cnt == xfer_len - 32'd1);
    assign gap_hit   = GAP_EN && rd_hs && !last_rd && (gap_cnt == GAP_LAST);
    assign s1_take   = s1_valid && (!dma_read_chnl_valid || dma_read_chnl_ready) && !gap_hit;
    assign s1_hold   = s1_valid && !s1_take;
    assign can_issue = (state == RD_BURST) && (issue_cnt != xfer_len) && !s1_hold;

    // A held s1 beat keeps re-reading its own address so the memory output stays put.
    logic [AW-1:0] rd_addr;
    assign rd_addr = AW'(base_idx + issue_cnt - (s1_hold ? 32'd1 : 32'd0));

    logic wr_hs, last_wr;
    assign wr_hs   = (state == WR_BURST) && dma_write_chnl_ready && dma_write_chnl_valid;
    assign last_wr = wr_hs && (beat_cnt == xfer_len - 32'd1);

    // Single write port: a DMA beat takes the port over a concurrent host write.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [63:0]   mem_wdata;
    assign mem_we    = wr_hs || host_we;
    assign mem_waddr = wr_hs ? AW'(base_idx + beat_cnt) : host_addr[AW-1:0];
    assign mem_wdata = wr_hs ? dma_write_chnl_data : host_wdata;

    dma64_beat_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (rd_addr),
        .rdata_a (mem_rdata),
        .raddr_b (host_addr[AW-1:0]),
        .rdata_b (host_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            ctrl_rdy             <= 1'b0;
            busy                 <= 1'b0;
            dma_write_chnl_ready <= 1'b0;
            dma_read_chnl_valid  <= 1'b0;
            dma_read_chnl_data   <= '0;
            s1_valid             <= 1'b0;
            base_idx             <= '0;
            xfer_len             <= '0;
            xfer_size            <= '0;
            issue_cnt            <= '0;
            beat_cnt             <= '0;
            gap_cnt              <= '0;
            err_pulse            <= 1'b0;
            err_code             <= ERR_NONE;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    ctrl_rdy <= 1'b1;
                    if (req_acc) begin
                        base_idx  <= req_idx;
                        xfer_len  <= req_len;
                        xfer_size <= req_size;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                        gap_cnt   <= '0;
                        s1_valid  <= 1'b0;
                        if (req_err != ERR_NONE) begin
                            err_pulse <= 1'b1;
                            err_code  <= req_err;
                        end
                        if (req_len != 32'd0) begin
                            state                <= dma_read_ctrl_valid ? RD_BURST : WR_BURST;
                            ctrl_rdy             <= 1'b0;
                            busy                 <= 1'b1;
                            dma_write_chnl_ready <= !dma_read_ctrl_valid;
                        end
                    end
                end
                RD_BURST: begin
                    if (can_issue) issue_cnt <= issue_cnt + 32'd1;
                    if (can_issue)    s1_valid <= 1'b1;
                    else if (s1_take) s1_valid <= 1'b0;
                    if (s1_take) begin
                        dma_read_chnl_valid <= 1'b1;
                        dma_read_chnl_data  <= mem_rdata;
                    end else if (rd_hs) begin
                        dma_read_chnl_valid <= 1'b0;
                    end
                    if (rd_hs) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        gap_cnt  <= gap_hit ? 32'd0 : gap_cnt + 32'd1;
                    end
                    if (last_rd) begin
                        state    <= IDLE;
                        ctrl_rdy <= 1'b1;
                        busy     <= 1'b0;
                        s1_valid <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (wr_hs) beat_cnt <= beat_cnt + 32'd1;
                    if (last_wr) begin
                        state                <= IDLE;
                        ctrl_rdy             <= 1'b1;
                        busy                 <= 1'b0;
                        dma_write_chnl_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dma_read_ctrl_ready  = ctrl_rdy;
    assign dma_write_ctrl_ready = ctrl_rdy;

    logic unused_ok;
    assign unused_ok = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user, xfer_size,
                         host_addr[31:AW]};

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Bench for dma64_mem_responder: a table of request vectors plus randomized reads
// checked against an array model of memory, with hand sequences for arbitration and reset.
module tb_dma64_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_rcv = 0, g_rcv = 0, wcv = 0, rd_rdy = 0, wch_v = 0;
    logic [31:0] c_idx = 0, c_len = 0;
    logic [2:0]  c_size = 3'b011;
    logic [63:0] wch_d = 0, host_wdata = 0;
    logic        host_we = 0;
    logic [31:0] host_addr = 0;

    logic        m_rc_rdy, m_wc_rdy, m_rv, m_wch_rdy, m_busy, m_ep;
    logic [63:0] m_rd, m_hrd;
    logic [1:0]  m_ec;
    logic        g_rc_rdy, g_wc_rdy, g_rv, g_wch_rdy, g_busy, g_ep;
    logic [63:0] g_rd, g_hrd;
    logic [1:0]  g_ec;

    dma64_mem_responder #(.MEM_DEPTH(64), .GAP_EVERY(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dma_read_ctrl_valid(m_rcv), .dma_read_ctrl_ready(m_rc_rdy),
        .dma_read_ctrl_data_index(c_idx), .dma_read_ctrl_data_length(c_len),
        .dma_read_ctrl_data_size(c_size), .dma_read_ctrl_data_user(6'd0),
        .dma_read_chnl_valid(m_rv), .dma_read_chnl_ready(rd_rdy), .dma_read_chnl_data(m_rd),
        .dma_write_ctrl_valid(wcv), .dma_write_ctrl_ready(m_wc_rdy),
        .dma_write_ctrl_data_index(c_idx), .dma_write_ctrl_data_length(c_len),
        .dma_write_ctrl_data_size(c_size), .dma_write_ctrl_data_user(6'd0),
        .dma_write_chnl_valid(wch_v), .dma_write_chnl_ready(m_wch_rdy), .dma_write_chnl_data(wch_d),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(m_hrd),
        .busy(m_busy), .err_pulse(m_ep), .err_code(m_ec)
    );

    dma64_mem_responder #(.MEM_DEPTH(64), .GAP_EVERY(4)) u_gap (
        .clk(clk), .rst_n(rst_n),
        .dma_read_ctrl_valid(g_rcv), .dma_read_ctrl_ready(g_rc_rdy),
        .dma_read_ctrl_data_index(c_idx), .dma_read_ctrl_data_length(c_len),
        .dma_read_ctrl_data_size(c_size), .dma_read_ctrl_data_user(6'd0),
        .dma_read_chnl_valid(g_rv), .dma_read_chnl_ready(rd_rdy), .dma_read_chnl_data(g_rd),
        .dma_write_ctrl_valid(1'b0), .dma_write_ctrl_ready(g_wc_rdy),
        .dma_write_ctrl_data_index(c_idx), .dma_write_ctrl_data_length(c_len),
        .dma_write_ctrl_data_size(c_size), .dma_write_ctrl_data_user(6'd0),
        .dma_write_chnl_valid(1'b0), .dma_write_chnl_ready(g_wch_rdy), .dma_write_chnl_data(wch_d),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(g_hrd),
        .busy(g_busy), .err_pulse(g_ep), .err_code(g_ec)
    );

    logic        sel_g = 0;
    wire         s_v      = sel_g ? g_rv     : m_rv;
    wire  [63:0] s_d      = sel_g ? g_rd     : m_rd;
    wire         s_busy   = sel_g ? g_busy   : m_busy;
    wire         s_rc_rdy = sel_g ? g_rc_rdy : m_rc_rdy;

    int          total = 0, bad = 0;
    logic [63:0] ref_mem [64];
    logic [1:0]  held_code = 2'b00;

    typedef struct {
        bit          wr;
        logic [31:0] idx;
        logic [31:0] len;
        logic [2:0]  size;
        logic [1:0]  exp_code;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input logic [31:0] idx, input logic [31:0] len,
                                             input logic [2:0] size);
        if (len == 0) return 2'b11;
        if (64'(idx) + 64'(len) > 64) return 2'b01;
        if (size != 3'b011) return 2'b10;
        return 2'b00;
    endfunction

    task automatic host_fill(input int mult, input int add);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            host_we = 1; host_addr = i; host_wdata = 64'(i * mult + add);
            ref_mem[i] = 64'(i * mult + add);
        end
        @(negedge clk);
        host_we = 0;
    endtask

    task automatic send_ctrl(input bit wr, input bit g, input logic [31:0] idx,
                             input logic [31:0] len, input logic [2:0] size);
        bit done = 0;
        @(negedge clk);
        c_idx = idx; c_len = len; c_size = size;
        if (wr) wcv = 1; else if (g) g_rcv = 1; else m_rcv = 1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (wr ? m_wc_rdy : (g ? g_rc_rdy : m_rc_rdy)) begin
                @(posedge clk); #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        wcv = 0; g_rcv = 0; m_rcv = 0;
        if (!done) chk("ctrl_accept_timeout", 0, 1);
    endtask

    task automatic err_check(input logic [1:0] code);
        @(negedge clk);
        chk("err_pulse", m_ep, code != 2'b00);
        if (code != 2'b00) held_code = code;
        chk("err_code", m_ec, held_code);
    endtask

    // gapn < 0: bubbles not checked; 0: no bubbles allowed; >0: one bubble per gapn beats.
    task automatic collect_read(input logic [31:0] idx, input logic [31:0] len,
                                input bit rnd, input int gapn);
        int k = 0, low = 0, wait_first = 0, cyc = 0;
        bit stall = 0;
        logic [63:0] prev_d = 0;
        while (k < int'(len) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            rd_rdy = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
            if (stall) begin
                chk("hold_valid", s_v, 1);
                chk("hold_data", s_d, prev_d);
            end
            if (s_v) begin
                if (k == 0) chk("latency_ok", wait_first >= 1, 1);
                if (rd_rdy) begin
                    chk($sformatf("beat%0d", k), s_d, ref_mem[6'(idx + k)]);
                    if (k > 0 && gapn >= 0)
                        chk($sformatf("bubble_before%0d", k), low,
                            (gapn > 0 && k % gapn == 0) ? 1 : 0);
                    k++; low = 0; stall = 0;
                end else begin
                    stall = 1; prev_d = s_d;
                end
            end else begin
                stall = 0;
                if (k == 0) wait_first++; else low++;
            end
        end
        if (k < int'(len)) chk("read_timeout", k, len);
        @(negedge clk);
        rd_rdy = 0;
        chk("busy_after_read", s_busy, 0);
        chk("ctrl_ready_after_read", s_rc_rdy, 1);
    endtask

    task automatic write_beats(input logic [31:0] idx, input logic [31:0] len, input bit a0);
        int k = 0, cyc = 0;
        while (k < int'(len) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            wch_v = ($urandom_range(0, 3) != 0);
            wch_d = a0 ? 64'(32'hA0 + k) : {$urandom, $urandom};
            if (wch_v && m_wch_rdy) begin
                ref_mem[6'(idx + k)] = wch_d;
                k++;
            end
        end
        if (k < int'(len)) chk("write_timeout", k, len);
        @(negedge clk);
        wch_v = 0;
        chk("busy_after_write", m_busy, 0);
        chk("wchnl_ready_after_write", m_wch_rdy, 0);
    endtask

    initial begin
        tbl[0] = '{0, 32'd0,  32'd32, 3'b011, 2'b00};
        tbl[1] = '{0, 32'd60, 32'd8,  3'b011, 2'b01};
        tbl[2] = '{0, 32'd10, 32'd4,  3'b010, 2'b10};
        tbl[3] = '{0, 32'd62, 32'd4,  3'b000, 2'b01};
        tbl[4] = '{0, 32'd5,  32'd0,  3'b011, 2'b11};
        tbl[5] = '{1, 32'd4,  32'd16, 3'b011, 2'b00};
        tbl[6] = '{1, 32'd63, 32'd2,  3'b111, 2'b01};
        tbl[7] = '{1, 32'd0,  32'd0,  3'b011, 2'b11};

        repeat (3) @(negedge clk);
        chk("rst_ctrl_ready", m_rc_rdy, 0);
        chk("rst_rd_valid", m_rv, 0);
        chk("rst_rd_data", m_rd, 0);
        chk("rst_wchnl_ready", m_wch_rdy, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_err", {m_ep, m_ec}, 0);
        chk("rst_host_rdata", m_hrd, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_ctrl_ready", m_rc_rdy, 1);

        host_fill(1, 100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); host_addr = i * 9;
            @(negedge clk); chk("host_read", m_hrd, 64'(i * 9 + 100));
        end

        for (int t = 0; t < 8; t++) begin
            send_ctrl(tbl[t].wr, 0, tbl[t].idx, tbl[t].len, tbl[t].size);
            err_check(tbl[t].exp_code);
            if (tbl[t].len == 0) begin
                chk("zero_len_idle", m_busy, 0);
                @(negedge clk);
                chk("zero_len_pulse_off", m_ep, 0);
            end else if (tbl[t].wr) begin
                write_beats(tbl[t].idx, tbl[t].len, t == 5);
            end else begin
                collect_read(tbl[t].idx, tbl[t].len, 0, 0);
            end
        end

        for (int i = 4; i < 20; i++) begin
            @(negedge clk); host_addr = i;
            @(negedge clk); chk($sformatf("host_after_wr%0d", i), m_hrd, 64'(32'hA0 + i - 4));
        end

        // Read and write offered together: read goes first, write right after.
        @(negedge clk);
        c_idx = 0; c_len = 3; c_size = 3'b011;
        m_rcv = 1; wcv = 1;
        @(posedge clk); #1;
        m_rcv = 0;
        @(negedge clk);
        chk("rd_first_busy", m_busy, 1);
        chk("rd_first_no_wchnl", m_wch_rdy, 0);
        c_idx = 40; c_len = 2;
        collect_read(0, 3, 0, 0);
        @(posedge clk); #1;
        wcv = 0;
        @(negedge clk);
        chk("wr_accepted_after_rd", m_wch_rdy, 1);
        write_beats(40, 2, 0);

        for (int r = 0; r < 6; r++) begin
            logic [31:0] idx, len;
            idx = $urandom_range(0, 63);
            len = $urandom_range(1, 20);
            send_ctrl(0, 0, idx, len, 3'b011);
            err_check(model_err(idx, len, 3'b011));
            collect_read(idx, len, 1, -1);
        end

        host_fill(3, 7);
        sel_g = 1;
        send_ctrl(0, 1, 2, 12, 3'b011);
        @(negedge clk);
        chk("gap_err_none", g_ep, 0);
        collect_read(2, 12, 1, 4);
        sel_g = 0;

        // Reset in the middle of a 16-beat read.
        send_ctrl(0, 0, 0, 16, 3'b011);
        rd_rdy = 1;
        begin
            int k = 0;
            for (int n = 0; n < 100 && k < 5; n++) begin
                @(negedge clk);
                if (m_rv) k++;
            end
            chk("beats_before_reset", k, 5);
        end
        rst_n = 0;
        #1;
        chk("abort_valid", m_rv, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_ctrl_ready", m_rc_rdy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_ctrl_ready", m_rc_rdy, 1);
        chk("post_rst_busy", m_busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_beats", m_rv, 0);
        end
        rd_rdy = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dma64_mem_responder.md
DMA64_MEM_RESPONDER -- requirements
Module: dma64_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, beats of 64-bit memory (power of 2).
REQ-002 SHALL have parameter GAP_EVERY, default 0, read-channel bubble after every GAP_EVERY beats; 0 = no bubbles.
REQ-003 SHALL have ports:
  clk  in  1  clock; all logic on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  dma_read_ctrl_valid  in  1  read request valid
  dma_read_ctrl_ready  out  1  read request accepted
  dma_read_ctrl_data_index  in  32  start beat
  dma_read_ctrl_data_length  in  32  beat count
  dma_read_ctrl_data_size  in  3  beat size; 3'b011 only legal value
  dma_read_ctrl_data_user  in  6  ignored
  dma_read_chnl_valid  out  1  read beat valid
  dma_read_chnl_ready  in  1  consumer ready
  dma_read_chnl_data  out  64  read beat
  dma_write_ctrl_valid / _ready / _data_index / _data_length / _data_size / _data_user  in/out/in/in/in/in  1/1/32/32/3/6  write request, same meaning as read
  dma_write_chnl_valid  in  1  write beat valid
  dma_write_chnl_ready  out  1  responder ready
  dma_write_chnl_data  in  64  write beat
  host_we  in  1  backdoor write enable
  host_addr  in  32  backdoor beat address (modulo MEM_DEPTH)
  host_wdata  in  64  backdoor write data
  host_rdata  out  64  backdoor read data, 1-cycle latency
  busy  out  1  high in any state but IDLE
  err_pulse  out  1  one-cycle error pulse
  err_code  out  2  01 out-of-range, 10 bad size, 11 zero length; held until next error

Function
REQ-004 SHALL implement FSM IDLE, RD_BURST, WR_BURST.
REQ-005 SHALL drive both ctrl_ready high only in IDLE; a request is accepted on valid&&ready.
REQ-006 SHALL accept read over write when both ctrl_valid are high in the same IDLE cycle; the write stays pending.
REQ-007 SHALL latch index, length and size at acceptance, then go to RD_BURST or WR_BURST.
REQ-008 SHALL assert dma_read_chnl_valid no earlier than 2 cycles after read acceptance (synchronous memory read plus output register).
REQ-009 SHALL hold dma_read_chnl_data and valid stable while valid && !ready.
REQ-010 SHALL deliver beat k = mem[(index+k) mod MEM_DEPTH], k = 0..length-1, in order; one beat per cycle under continuous ready when GAP_EVERY = 0.
REQ-011 SHALL deassert read valid for exactly one cycle after every GAP_EVERY delivered beats when GAP_EVERY > 0; the final beat is never followed by a bubble.
REQ-012 SHALL assert dma_write_chnl_ready throughout WR_BURST and store each accepted beat k at (index+k) mod MEM_DEPTH.
REQ-013 SHALL return to IDLE the cycle after the last beat handshake; ctrl_ready rises that same cycle.
REQ-014 SHALL, on index+length > MEM_DEPTH, complete the full transfer with wrapped addresses and pulse err_pulse with code 01 at acceptance.
REQ-015 SHALL, on size != 3'b011, transfer normally and pulse err code 10.
REQ-016 SHALL, on length 0, pulse err code 11, move no beats and stay in IDLE.
REQ-017 SHALL use code 01 when out-of-range and bad size occur together.
REQ-018 SHALL apply host_we writes every cycle; a write-channel beat to the same address in the same cycle wins.
REQ-019 SHALL compute address arithmetic in 32 bits and truncate to log2(MEM_DEPTH) bits.

Reset
REQ-020 SHALL reset, on rst_n low: state IDLE; ctrl_ready 0 during reset; chnl valid/ready 0; read data 0; busy 0; err_pulse 0; err_code 0; host_rdata 0; memory contents not reset.
REQ-021 SHALL abort any burst when reset is asserted mid-transfer; after release the block is in IDLE with no beats pending.

Structure
REQ-022 SHALL take the state enum, DMA_SIZE_64 = 3'b011 and the err_code constants from shared package dma64_pkg.
REQ-023 SHALL place storage in sub-module dma64_beat_mem: one write port, two synchronous read ports (burst, host).

Verification
REQ-024 SHALL check: host preloads mem[i] = i+100 for i = 0..31; read idx 0 len 32 with ready held high -> 32 beats 100..131, contiguous, then busy falls.
REQ-025 SHALL check: write idx 4 len 16 data 0xA0+k, then host read of 4..19 -> 0xA0..0xAF.
REQ-026 SHALL check: MEM_DEPTH 64, read idx 60 len 8 -> err code 01 pulse; beats from addresses 60..63, 0..3.
REQ-027 SHALL check: read and write ctrl valid in the same cycle -> read served first; write accepted the cycle after the read returns to IDLE.
REQ-028 SHALL check: GAP_EVERY 4, read len 12 with random ready -> 12 beats, data held during stalls, bubble after beats 4 and 8.
REQ-029 SHALL check: rst_n low at beat 5 of a 16-beat read -> valid 0 immediately; after release ctrl_ready 1 and busy 0.
